ofd_pipe_bank: RTL and testbench

//   Parametrised output-register bank with valid tagging.
//   - Generalises the fixed 4-bit output flop: configurable width, pipeline depth, reset/init value and hold mode.
//   - Adds clock enable, flush, and a transfer counter.
//   - Sits at the pad side of the design; drives registered outputs off-chip or toward the IO boundary.

---
 rtl/ofd_pipe_bank.sv | 113 +++++++++++
 tb/tb_ofd_pipe_bank.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/ofd_pipe_bank.sv
// ofd_pipe_bank: pad-side output register bank with valid tagging.
// A DEPTH-stage data/valid pipe with clock enable, valid-only flush,
// optional hold-last output stage and a wrapping transfer counter.
// Q/QV/XCNT come straight from flops; nothing combinational reaches the pins.
module ofd_pipe_bank #(
    parameter int unsigned      WIDTH = 4,
    parameter int unsigned      DEPTH = 1,
    parameter logic [WIDTH-1:0] INIT  = '0,
    parameter int unsigned      MODE  = 0,
    parameter int unsigned      CNT_W = 16
) (
    input  logic             CK,
    input  logic             RST,
    input  logic             CE,
    input  logic             FLUSH,
    input  logic [WIDTH-1:0] D,
    input  logic             DV,
    output logic [WIDTH-1:0] Q,
    output logic             QV,
    output logic [CNT_W-1:0] XCNT
);

    localparam int unsigned LAST = DEPTH - 1;

    // Reject unsupported configurations at elaboration.
    if (WIDTH < 1 || WIDTH > 64) begin : g_bad_width
        $error("ofd_pipe_bank: WIDTH must be in 1..64");
    end
    if (DEPTH < 1 || DEPTH > 8) begin : g_bad_depth
        $error("ofd_pipe_bank: DEPTH must be in 1..8");
    end
    if (MODE > 1) begin : g_bad_mode
        $error("ofd_pipe_bank: MODE must be 0 or 1");
    end
    if (CNT_W < 1 || CNT_W > 64) begin : g_bad_cnt
        $error("ofd_pipe_bank: CNT_W must be in 1..64");
    end

    logic [WIDTH-1:0] s_q [DEPTH];
    logic [WIDTH-1:0] s_d [DEPTH];
    logic             v_q [DEPTH];
    logic             v_d [DEPTH];
    logic [CNT_W-1:0] xcnt_q;
    logic [CNT_W-1:0] xcnt_d;

    // Valid bit arriving at the last stage this cycle (DV itself for a single stage).
    logic last_in_v;

    // Select the feed of the last stage without indexing below stage 0.
    if (DEPTH == 1) begin : g_feed_single
        assign last_in_v = DV;
    end else begin : g_feed_chain
        assign last_in_v = v_q[DEPTH-2];
    end

    // A word counts as transferred only when it really enters the last stage.
    logic take_last;
    assign take_last = CE && last_in_v && !FLUSH;

    // Next-state for data stages, valid bits and transfer counter.
    always_comb begin
        for (int k = 0; k < int'(DEPTH); k++) begin
            s_d[k] = s_q[k];
            v_d[k] = v_q[k];
        end
        xcnt_d = xcnt_q;

        if (CE) begin
            s_d[0] = D;
            v_d[0] = DV;
            for (int k = 1; k < int'(DEPTH); k++) begin
                s_d[k] = s_q[k-1];
                v_d[k] = v_q[k-1];
            end
            // Hold-last: output data only moves when a real word arrives.
            if (MODE == 1 && !take_last) begin
                s_d[LAST] = s_q[LAST];
            end
            if (take_last) begin
                xcnt_d = xcnt_q + CNT_W'(1);
            end
        end

        // Flush kills every valid tag but leaves the data path alone.
        if (FLUSH) begin
            for (int k = 0; k < int'(DEPTH); k++) begin
                v_d[k] = 1'b0;
            end
        end
    end

    // State registers with synchronous reset overriding CE and FLUSH.
    always_ff @(posedge CK) begin
        if (RST) begin
            for (int k = 0; k < int'(DEPTH); k++) begin
                s_q[k] <= INIT;
                v_q[k] <= 1'b0;
            end
            xcnt_q <= '0;
        end else begin
            for (int k = 0; k < int'(DEPTH); k++) begin
                s_q[k] <= s_d[k];
                v_q[k] <= v_d[k];
            end
            xcnt_q <= xcnt_d;
        end
    end

    assign Q    = s_q[LAST];
    assign QV   = v_q[LAST];
    assign XCNT = xcnt_q;

endmodule

// File: tb/tb_ofd_pipe_bank.sv
// Bench for ofd_pipe_bank: several configurations side by side, directed
// vectors with hand-computed expectations queued per target edge and a
// monitor that pops and compares after each rising edge.
module tb_ofd_pipe_bank;

    localparam int N = 6;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst [N];
    logic        ce  [N];
    logic        fl  [N];
    logic [3:0]  d   [N];
    logic        dv  [N];
    logic [3:0]  q   [N];
    logic        qv  [N];
    logic [15:0] xc  [N];

    logic [3:0] xc4;
    logic [0:0] q5;
    logic [15:0] xc0, xc1, xc2, xc3, xc5;

    // u0: single stage, INIT=A
    ofd_pipe_bank #(.WIDTH(4), .DEPTH(1), .INIT(4'hA), .MODE(0), .CNT_W(16)) u0 (
        .CK(clk), .RST(rst[0]), .CE(ce[0]), .FLUSH(fl[0]), .D(d[0]), .DV(dv[0]),
        .Q(q[0]), .QV(qv[0]), .XCNT(xc0));
    // u1: three stages, transparent
    ofd_pipe_bank #(.WIDTH(4), .DEPTH(3), .INIT(4'h0), .MODE(0), .CNT_W(16)) u1 (
        .CK(clk), .RST(rst[1]), .CE(ce[1]), .FLUSH(fl[1]), .D(d[1]), .DV(dv[1]),
        .Q(q[1]), .QV(qv[1]), .XCNT(xc1));
    // u2: two stages, hold-last
    ofd_pipe_bank #(.WIDTH(4), .DEPTH(2), .INIT(4'h0), .MODE(1), .CNT_W(16)) u2 (
        .CK(clk), .RST(rst[2]), .CE(ce[2]), .FLUSH(fl[2]), .D(d[2]), .DV(dv[2]),
        .Q(q[2]), .QV(qv[2]), .XCNT(xc2));
    // u3: two stages, transparent
    ofd_pipe_bank #(.WIDTH(4), .DEPTH(2), .INIT(4'h0), .MODE(0), .CNT_W(16)) u3 (
        .CK(clk), .RST(rst[3]), .CE(ce[3]), .FLUSH(fl[3]), .D(d[3]), .DV(dv[3]),
        .Q(q[3]), .QV(qv[3]), .XCNT(xc3));
    // u4: four stages, 4-bit counter
    ofd_pipe_bank #(.WIDTH(4), .DEPTH(4), .INIT(4'h0), .MODE(0), .CNT_W(4)) u4 (
        .CK(clk), .RST(rst[4]), .CE(ce[4]), .FLUSH(fl[4]), .D(d[4]), .DV(dv[4]),
        .Q(q[4]), .QV(qv[4]), .XCNT(xc4));
    // u5: minimal 1x1 configuration
    ofd_pipe_bank #(.WIDTH(1), .DEPTH(1), .INIT(1'b0), .MODE(0), .CNT_W(16)) u5 (
        .CK(clk), .RST(rst[5]), .CE(ce[5]), .FLUSH(fl[5]), .D(d[5][0:0]), .DV(dv[5]),
        .Q(q5), .QV(qv[5]), .XCNT(xc5));

    assign xc[0] = xc0;
    assign xc[1] = xc1;
    assign xc[2] = xc2;
    assign xc[3] = xc3;
    assign xc[4] = {12'h000, xc4};
    assign xc[5] = xc5;
    assign q[5]  = {3'b000, q5};

    typedef struct {
        int          cyc;
        int          id;
        logic [3:0]  q;
        logic        qv;
        logic [15:0] x;
        string       name;
    } exp_t;

    exp_t exp_q[$];
    int cyc    = 0;
    int checks = 0;
    int errors = 0;

    // Queue the outputs expected right after the coming rising edge.
    task automatic push_exp(input int id, input logic [3:0] eq, input logic eqv,
                            input logic [15:0] ex, input string name);
        exp_t e;
        e.cyc = cyc + 1; e.id = id; e.q = eq; e.qv = eqv; e.x = ex; e.name = name;
        exp_q.push_back(e);
    endtask

    task automatic drv(input int id, input logic r, input logic c, input logic f,
                       input logic [3:0] dd, input logic v);
        rst[id] = r; ce[id] = c; fl[id] = f; d[id] = dd; dv[id] = v;
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    // Monitor: after each edge, compare every expectation targeting this edge.
    always @(posedge clk) begin
        cyc = cyc + 1;
        #1;
        while (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
            exp_t e;
            e = exp_q.pop_front();
            checks = checks + 1;
            if (e.cyc != cyc) begin
                errors = errors + 1;
                $display("FAIL %s u%0d: check scheduled for edge %0d seen at edge %0d",
                         e.name, e.id, e.cyc, cyc);
            end else if (q[e.id] !== e.q || qv[e.id] !== e.qv || xc[e.id] !== e.x) begin
                errors = errors + 1;
                $display("FAIL %s u%0d: got Q=%h QV=%b XCNT=%0d, expected Q=%h QV=%b XCNT=%0d",
                         e.name, e.id, q[e.id], qv[e.id], xc[e.id], e.q, e.qv, e.x);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < N; i++) drv(i, 1'b1, 1'b1, 1'b0, 4'h0, 1'b0);
        tick();
        // Reset held for a second edge: INIT on Q, no valid, counter clear.
        push_exp(0, 4'hA, 1'b0, 16'd0, "rst_init");
        for (int i = 1; i < N; i++) push_exp(i, 4'h0, 1'b0, 16'd0, "rst_zero");
        tick();
        for (int i = 0; i < N; i++) drv(i, 1'b0, 1'b1, 1'b0, 4'h0, 1'b0);

        // Single stage: first word, valid drop, CE freeze, flush with CE=0.
        drv(0, 0, 1, 0, 4'h5, 1); push_exp(0, 4'h5, 1, 16'd1, "t1_first"); tick();
        drv(0, 0, 1, 0, 4'h3, 0); push_exp(0, 4'h3, 0, 16'd1, "t1_dv_low"); tick();
        drv(0, 0, 0, 0, 4'h7, 1); push_exp(0, 4'h3, 0, 16'd1, "t1_ce_freeze"); tick();
        drv(0, 0, 1, 0, 4'h6, 1); push_exp(0, 4'h6, 1, 16'd2, "t1_word2"); tick();
        drv(0, 0, 0, 1, 4'h9, 1); push_exp(0, 4'h6, 0, 16'd2, "t1_flush_ce0"); tick();
        drv(0, 0, 1, 0, 4'h0, 0);

        // 1x1 configuration.
        drv(5, 0, 1, 0, 4'h1, 1); push_exp(5, 4'h1, 1, 16'd1, "w1_word"); tick();
        drv(5, 0, 1, 0, 4'h0, 0); push_exp(5, 4'h0, 0, 16'd1, "w1_idle"); tick();

        // Latency through three stages.
        drv(1, 0, 1, 0, 4'h1, 1); push_exp(1, 4'h0, 0, 16'd0, "t2_e1"); tick();
        drv(1, 0, 1, 0, 4'h2, 1); push_exp(1, 4'h0, 0, 16'd0, "t2_e2"); tick();
        drv(1, 0, 1, 0, 4'h3, 1); push_exp(1, 4'h1, 1, 16'd1, "t2_e3"); tick();
        drv(1, 0, 1, 0, 4'h0, 0); push_exp(1, 4'h2, 1, 16'd2, "t2_e4"); tick();
        drv(1, 0, 1, 0, 4'h0, 0); push_exp(1, 4'h3, 1, 16'd3, "t2_e5"); tick();
        drv(1, 0, 1, 0, 4'h0, 0); push_exp(1, 4'h0, 0, 16'd3, "t2_e6"); tick();

        // CE stall stretches latency one-for-one.
        drv(1, 0, 1, 0, 4'h7, 1); push_exp(1, 4'h0, 0, 16'd3, "t3_in"); tick();
        for (int i = 0; i < 4; i++) begin
            drv(1, 0, 0, 0, 4'hF, 1); push_exp(1, 4'h0, 0, 16'd3, "t3_stall"); tick();
        end
        drv(1, 0, 1, 0, 4'h0, 0); push_exp(1, 4'h0, 0, 16'd3, "t3_e6"); tick();
        drv(1, 0, 1, 0, 4'h0, 0); push_exp(1, 4'h7, 1, 16'd4, "t3_e7"); tick();
        drv(1, 0, 1, 0, 4'h0, 0); push_exp(1, 4'h0, 0, 16'd4, "t3_e8"); tick();

        // Flush with three words in flight, then a fresh word.
        drv(1, 0, 1, 0, 4'h1, 1); push_exp(1, 4'h0, 0, 16'd4, "t4_g1"); tick();
        drv(1, 0, 1, 0, 4'h2, 1); push_exp(1, 4'h0, 0, 16'd4, "t4_g2"); tick();
        drv(1, 0, 1, 0, 4'h3, 1); push_exp(1, 4'h1, 1, 16'd5, "t4_g3"); tick();
        drv(1, 0, 1, 1, 4'h4, 1); push_exp(1, 4'h2, 0, 16'd5, "t4_flush"); tick();
        drv(1, 0, 1, 0, 4'h5, 1); push_exp(1, 4'h3, 0, 16'd5, "t4_post1"); tick();
        drv(1, 0, 1, 0, 4'h0, 0); push_exp(1, 4'h4, 0, 16'd5, "t4_post2"); tick();
        drv(1, 0, 1, 0, 4'h0, 0); push_exp(1, 4'h5, 1, 16'd6, "t4_new"); tick();
        drv(1, 0, 1, 0, 4'h0, 0); push_exp(1, 4'h0, 0, 16'd6, "t4_drain"); tick();

        // Hold-last (u2) against transparent (u3) with identical stimulus.
        drv(2, 0, 1, 0, 4'h9, 1); drv(3, 0, 1, 0, 4'h9, 1);
        push_exp(2, 4'h0, 0, 16'd0, "t5_h_in"); push_exp(3, 4'h0, 0, 16'd0, "t5_t_in"); tick();
        drv(2, 0, 1, 0, 4'hF, 0); drv(3, 0, 1, 0, 4'hF, 0);
        push_exp(2, 4'h9, 1, 16'd1, "t5_h_out"); push_exp(3, 4'h9, 1, 16'd1, "t5_t_out"); tick();
        for (int i = 0; i < 4; i++) begin
            push_exp(2, 4'h9, 0, 16'd1, "t5_h_hold"); push_exp(3, 4'hF, 0, 16'd1, "t5_t_pass"); tick();
        end
        drv(2, 0, 1, 0, 4'h0, 0); drv(3, 0, 1, 0, 4'h0, 0);

        // Seventeen words through a 4-bit counter: wraps to 1.
        for (int i = 1; i <= 17; i++) begin
            drv(4, 0, 1, 0, 4'(i), 1);
            if (i == 3)  push_exp(4, 4'h0, 0, 16'd0, "t6_pre");
            if (i == 4)  push_exp(4, 4'h1, 1, 16'd1, "t6_first");
            if (i == 16) push_exp(4, 4'hD, 1, 16'd13, "t6_mid");
            tick();
        end
        drv(4, 0, 1, 0, 4'h0, 0); push_exp(4, 4'hF, 1, 16'd15, "t6_max"); tick();
        push_exp(4, 4'h0, 1, 16'd0, "t6_wrap0"); tick();
        push_exp(4, 4'h1, 1, 16'd1, "t6_wrap1"); tick();
        push_exp(4, 4'h0, 0, 16'd1, "t6_drained"); tick();

        // Reset mid-stream discards in-flight words.
        drv(4, 0, 1, 0, 4'h3, 1); push_exp(4, 4'h0, 0, 16'd1, "t6_k1"); tick();
        drv(4, 0, 1, 0, 4'h4, 1); push_exp(4, 4'h0, 0, 16'd1, "t6_k2"); tick();
        drv(4, 1, 1, 0, 4'h5, 1); push_exp(4, 4'h0, 0, 16'd0, "t6_rst"); tick();
        for (int i = 0; i < 5; i++) begin
            drv(4, 0, 1, 0, 4'h0, 0); push_exp(4, 4'h0, 0, 16'd0, "t6_no_stale"); tick();
        end

        // Let the monitor consume everything, bounded.
        for (int i = 0; i < 5 && exp_q.size() > 0; i++) @(posedge clk);
        #2;
        if (exp_q.size() > 0) begin
            $display("FAIL drain: %0d expectations never compared, expected 0", exp_q.size());
            errors = errors + exp_q.size();
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
